// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mc_ctrl_fsm                                                  |
// | Description : Multicycle RV32I control FSM. Drives datapath controls per   |
// |               state, applies a configurable memory access latency to the   |
// |               IF and MEM states, halts on ECALL with x17 == 10 and counts  |
// |               retired instructions.                                        |
// |               Build option: define MEM_READY_HS_EN to replace the fixed    |
// |               MEM_LAT latency with a mem_ready handshake.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mc_ctrl_fsm #(
  parameter int MEM_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [31:0]      x17_val,
`ifdef MEM_READY_HS_EN
  input  logic             mem_ready,
`endif
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             ir_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic [1:0]       mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             reg_write,
  output logic             is_halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam logic [6:0] c_opc_op     = 7'b0110011;
  localparam logic [6:0] c_opc_op_imm = 7'b0010011;
  localparam logic [6:0] c_opc_load   = 7'b0000011;
  localparam logic [6:0] c_opc_store  = 7'b0100011;
  localparam logic [6:0] c_opc_branch = 7'b1100011;
  localparam logic [6:0] c_opc_jal    = 7'b1101111;
  localparam logic [6:0] c_opc_jalr   = 7'b1100111;
  localparam logic [6:0] c_opc_system = 7'b1110011;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_retire;
  logic             w_last;
  logic [CNT_W-1:0] r_retired;

  assign state   = r_state;
  assign retired = r_retired;

`ifdef MEM_READY_HS_EN
  // Memory completion comes straight from the handshake.
  assign w_last = mem_ready;
`else
  localparam logic [3:0] c_acnt_last = 4'(MEM_LAT - 1);

  logic [3:0] r_acnt;
  logic       w_in_access;

  assign w_in_access = (r_state == S_IF) || (r_state == S_MEM);
  assign w_last      = (r_acnt == c_acnt_last);

  // Access cycle counter: runs during IF/MEM, cleared on the exiting cycle.
  always_ff @(posedge clk) begin
    if (reset || !w_in_access || w_last) r_acnt <= '0;
    else                                 r_acnt <= r_acnt + 4'd1;
  end
`endif

  // State register and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IF;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_retired <= r_retired + CNT_W'(1);
    end
  end

  // Next-state, retire decision and per-state datapath controls.
  always_comb begin
    w_next        = r_state;
    w_retire      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    reg_write     = 1'b0;
    is_halted     = 1'b0;
    case (r_state)
      S_IF: begin
        mem_read = 1'b1;
        if (w_last) begin
          // PC <= PC + 4 while the fetched word is latched into IR.
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = 2'b01;
          w_next    = S_ID;
        end
      end
      S_ID: begin
        // Speculative branch/jump target: ALUOut = old_pc + imm.
        alu_src_b = 2'b10;
        if (opcode == c_opc_system) begin
          if (x17_val == 32'd10) begin
            w_next = S_HALT;
          end else begin
            w_next   = S_IF;
            w_retire = 1'b1;
          end
        end else begin
          w_next = S_EX;
        end
      end
      S_EX: begin
        case (opcode)
          c_opc_op: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
            w_next    = S_WB;
          end
          c_opc_op_imm: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = 2'b10;
            w_next    = S_WB;
          end
          c_opc_load, c_opc_store: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            w_next    = S_MEM;
          end
          c_opc_branch: begin
            alu_src_a     = 1'b1;
            alu_op        = 2'b01;
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
            w_next        = S_IF;
            w_retire      = 1'b1;
          end
          c_opc_jal: begin
            pc_write  = 1'b1;
            pc_source = 2'b01;
            w_next    = S_WB;
          end
          c_opc_jalr: begin
            // Datapath clears bit 0 of the ALU result on the PC path.
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            pc_write  = 1'b1;
            w_next    = S_WB;
          end
          default: w_next = S_IF;
        endcase
      end
      S_MEM: begin
        iord      = 1'b1;
        mem_read  = (opcode == c_opc_load);
        mem_write = (opcode == c_opc_store);
        if (w_last) begin
          if (opcode == c_opc_load) begin
            w_next = S_WB;
          end else begin
            w_next   = S_IF;
            w_retire = (opcode == c_opc_store);
          end
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        if (opcode == c_opc_load)                             mem_to_reg = 2'b01;
        else if (opcode == c_opc_jal || opcode == c_opc_jalr) mem_to_reg = 2'b10;
        w_next   = S_IF;
        w_retire = 1'b1;
      end
      S_HALT: begin
        is_halted = 1'b1;
      end
      default: w_next = S_IF;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Parametrised multicycle control FSM for the RV32I multicycle core. It generates datapath control signals per state and supports a configurable memory access latency instead of fixed fetch/memory state chains. It detects the halting ECALL (x17 == 10), enters a sticky halt state, and counts retired instructions. It sits between the instruction register and opcode decode on one side and the datapath muxes, register file, memory and PC on the other.

Parameters:
MEM_LAT, 4, cycles per memory access (IF and MEM); legal range 1..15.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
opcode  in  7  IR[6:0]
x17_val  in  32  register x17 read value
mem_ready  in  1  memory done; exists only with MEM_READY_HS_EN
pc_write  out  1  unconditional PC write
pc_write_cond  out  1  PC write if branch taken (datapath compare)
ir_write  out  1  latch IR and old_pc
iord  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
mem_read  out  1  memory read
mem_write  out  1  memory write
mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC (link)
alu_src_a  out  1  0 = old_pc, 1 = rs1
alu_src_b  out  2  00 rs2, 01 const 4, 10 imm
alu_op  out  2  00 add, 01 branch compare, 10 funct-decoded
pc_source  out  2  00 ALU result, 01 ALUOut
reg_write  out  1  register file write
is_halted  out  1  halt state
state  out  3  IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5
retired  out  CNT_W  retired-instruction count

Behaviour:
- Reset: the clock edge with reset=1 forces state=IF, the access counter to 0, and retired to 0. This overrides every state, including mid-access and HALT.
- Outputs are Moore or Moore+opcode combinational. Any output not listed for a state is 0. The post-reset outputs are therefore those of IF: mem_read=1, all others 0.
- Access counter acnt counts 0..MEM_LAT-1 in IF and MEM and clears on state exit. The last access cycle is acnt == MEM_LAT-1.
- IF: mem_read=1, iord=0.
  - Last cycle: ir_write=1, pc_write=1, alu_src_a=0, alu_src_b=01, pc_source=00 (PC <= PC+4).
  - Next state: ID.
- ID: alu_src_a=0, alu_src_b=10, alu_op=00, giving ALUOut = old_pc + imm.
  - ECALL with x17_val == 10: next state HALT.
  - ECALL otherwise: next state IF, retire.
  - All other opcodes: next state EX.
- EX, by opcode:
  - OP: a=1, b=00, op=10; next WB.
  - OP_IMM: a=1, b=10, op=10; next WB.
  - LOAD/STORE: a=1, b=10, op=00; next MEM.
  - BRANCH: a=1, b=00, op=01, pc_write_cond=1, pc_source=01; next IF, retire.
  - JAL: pc_write=1, pc_source=01; next WB.
  - JALR: a=1, b=10, op=00, pc_write=1, pc_source=00 (datapath clears bit 0); next WB.
  - Undefined opcode: next IF, no retire.
- MEM: iord=1; mem_read=1 for LOAD, mem_write=1 for STORE.
  - Held MEM_LAT cycles.
  - Last cycle: LOAD goes to WB; STORE goes to IF and retires.
- WB: reg_write=1; mem_to_reg=01 for LOAD, 10 for JAL/JALR, 00 otherwise. Next IF, retire.
- HALT: is_halted=1, all other controls 0. Held until reset; opcode changes are ignored.
- Retire: retired += 1 on the edge that enters IF from a completing instruction. Wraps modulo 2^CNT_W.
- MEM_LAT=1: IF and MEM each take a single cycle, and last-cycle actions happen in that same cycle.

Optional Feature:
MEM_READY_HS_EN
- Defined: the mem_ready port exists and MEM_LAT/acnt are unused. IF and MEM hold (minimum 1 cycle) until mem_ready=1 is sampled. "Last cycle" means the cycle with mem_ready=1. mem_read/mem_write stay asserted while waiting.
- Undefined: fixed MEM_LAT latency; no mem_ready port.

Test Plan:
- MEM_LAT=4, opcode OP after reset:
  - Cycles 0-3 in IF; ir_write and pc_write only in cycle 3.
  - ID in cycle 4, EX in cycle 5 (alu_op=10), WB in cycle 6 (reg_write=1).
  - IF in cycle 7 with retired=1.
- LOAD: IF ×4, ID, EX, MEM ×4 (iord=1, mem_read=1), WB with mem_to_reg=01; retired increments after 11 cycles. STORE: mem_write=1 ×4, no WB, 10 cycles.
- BRANCH: pc_write_cond=1 and pc_source=01 in EX only; 6-cycle instruction. JAL: pc_write in EX, mem_to_reg=10 in WB.
- ECALL with x17_val=10: HALT after ID, is_halted=1 for 20 cycles, retired unchanged; reset → state=0. ECALL with x17_val=5: back to IF, retired+1.
- Reset asserted in MEM cycle 2 of a STORE: state=IF next cycle, mem_write=0, retired=0. With CNT_W=4, 16 OP instructions wrap retired to 0.
- MEM_READY_HS_EN: hold mem_ready=0 for 6 IF cycles, then 1 → ir_write only in the mem_ready=1 cycle, mem_read=1 throughout.
